// File: rtl/arb_client_mux_pkg.sv
// Shared types and helpers for the arbiter client mux: FSM state, lane count
// type and the lane-index width helper.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef int unsigned lane_count_t;

    // A single lane still needs one index bit so that vectors never collapse to zero width.
    function automatic int idx_width(input lane_count_t n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_client_mux_lane_fifo.sv
// Per-lane FIFO: registered occupancy count, no bypass, head entry always visible.
module lane_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/arb_client_mux.sv
// Requestor-side companion to a round-robin arbiter: N lane FIFOs feed one
// valid/ready output slot. Optional grant checker under ARB_GRANT_CHECK_EN.
module arb_client_mux
    import arb_pkg::*;
#(
    parameter lane_count_t N     = 4,
    parameter int          DW    = 32,
    parameter int          DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         arb_req,
    input  logic [N-1:0]         arb_grant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 grant_err
);

    localparam int IW = idx_width(N);

    state_t        state;
    logic [N-1:0]  full;
    logic [N-1:0]  empty;
    logic [N-1:0]  nonempty;
    logic [N-1:0]  pop;
    logic [DW-1:0] head [N];
    logic          slot_free;
    logic          grant_ok;
    logic [IW-1:0] grant_idx;

    for (genvar g = 0; g < N; g++) begin : g_lane
        lane_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (in_valid[g]),
            .push_data (in_data[g*DW +: DW]),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (head[g])
        );
    end

    assign in_ready  = ~full;
    assign nonempty  = ~empty;
    assign slot_free = !out_valid || out_ready;

    // Requests go out only from IDLE; WAIT stays silent so a 1-entry lane is never granted twice.
    assign arb_req  = (state == IDLE && slot_free) ? nonempty : '0;
    assign grant_ok = (state == WAIT) && $onehot(arb_grant) && |(arb_grant & nonempty);
    assign pop      = grant_ok ? arb_grant : '0;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (arb_grant[i]) grant_idx = IW'(i);
        end
    end

    // Bad or missing grants simply fall back to IDLE and request again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_req != '0) state <= WAIT;
                end
                WAIT: begin
                    state <= IDLE;
                    if (grant_ok) begin
                        out_valid <= 1'b1;
                        out_data  <= head[grant_idx];
                        out_src   <= grant_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CHECK_EN
    logic grant_bad;
    logic grant_err_q;

    assign grant_bad = (state == IDLE) ? |arb_grant : !grant_ok;
    assign grant_err = grant_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         grant_err_q <= 1'b0;
        else if (grant_bad) grant_err_q <= 1'b1;
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(arb_grant));
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_client_mux.sv
// Self-checking bench for arb_client_mux: directed scenarios with a manual or
// round-robin grant source, plus a randomized run against a queue-based model.
module tb_arb_client_mux;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            grant_err;

    int total = 0;
    int bad   = 0;

    logic         manual = 1'b1;
    logic [N-1:0] manual_grant = '0;
    int           rr_last;

    logic [DW-1:0] model_q [N][$];

`ifdef ARB_GRANT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    arb_client_mux #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Grant source: either a scripted grant or a registered round-robin arbiter.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_grant <= '0;
            rr_last   <= N - 1;
        end else if (manual) begin
            arb_grant <= manual_grant;
        end else begin
            int w;
            w = rr_pick(arb_req, rr_last);
            if (w >= 0) begin
                arb_grant <= N'(1) << w;
                rr_last   <= w;
            end else begin
                arb_grant <= '0;
            end
        end
    end

    task automatic reset_dut();
        rst_n        = 1'b0;
        in_valid     = '0;
        out_ready    = 1'b0;
        manual       = 1'b1;
        manual_grant = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) model_q[i].delete();
    endtask

    task automatic test_reset();
        reset_dut();
        total += 6;
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL reset_arb_req: got %b expected 0000", arb_req); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        if (out_src !== '0) begin bad++; $display("[TB] FAIL reset_out_src: got %0d expected 0", out_src); end
        if (grant_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant_err: got %b expected 0", grant_err); end
        if (in_ready !== '1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1111", in_ready); end
    endtask

    task automatic test_single_lane();
        reset_dut();
        out_ready = 1'b1;
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 32'hA5A5_0001;
        @(negedge clk);
        in_valid = '0;
        total++;
        if (arb_req !== 4'b0100) begin bad++; $display("[TB] FAIL single_req: got %b expected 0100", arb_req); end
        manual_grant = 4'b0100;
        @(negedge clk);
        manual_grant = '0;
        total += 2;
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL single_wait_req: got %b expected 0000", arb_req); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
        if (out_data !== 32'hA5A5_0001) begin bad++; $display("[TB] FAIL single_data: got %h expected a5a50001", out_data); end
        if (out_src !== 2'd2) begin bad++; $display("[TB] FAIL single_src: got %0d expected 2", out_src); end
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drained_valid: got %b expected 0", out_valid); end
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL single_drained_req: got %b expected 0000", arb_req); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        manual    = 1'b0;
        out_ready = 1'b1;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'h1000_0000 + i;
        @(negedge clk);
        in_valid = '0;
        // First item 3 cycles after the push, then one every other cycle.
        for (int c = 1; c <= 10; c++) begin
            logic         exp_v;
            int           exp_src;
            exp_v   = (c >= 3) && (c <= 9) && ((c - 3) % 2 == 0);
            exp_src = (c - 3) / 2;
            total++;
            if (out_valid !== exp_v) begin
                bad++; $display("[TB] FAIL rr_valid_c%0d: got %b expected %b", c, out_valid, exp_v);
            end else if (exp_v && (out_src !== 2'(exp_src) || out_data !== 32'h1000_0000 + exp_src)) begin
                bad++; $display("[TB] FAIL rr_item_c%0d: got src %0d data %h expected src %0d data %h",
                                c, out_src, out_data, exp_src, 32'h1000_0000 + exp_src);
            end
            if (c < 10) @(negedge clk);
        end
        total += 2;
        if (in_ready !== '1) begin bad++; $display("[TB] FAIL rr_drained_ready: got %b expected 1111", in_ready); end
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL rr_drained_req: got %b expected 0000", arb_req); end
    endtask

    task automatic test_backpressure();
        int waited;
        reset_dut();
        manual    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        in_data[0 +: DW] = 32'hBEEF_0000;
        @(negedge clk);
        in_data[0 +: DW] = 32'hBEEF_0001;
        @(negedge clk);
        in_valid = '0;
        waited = 0;
        while (!out_valid && waited < 10) begin @(negedge clk); waited++; end
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0000) begin
            bad++; $display("[TB] FAIL bp_first: got valid %b data %h expected valid 1 data beef0000", out_valid, out_data);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (arb_req !== '0 || out_valid !== 1'b1 || out_data !== 32'hBEEF_0000) begin
                bad++; $display("[TB] FAIL bp_hold_%0d: got req %b valid %b data %h expected req 0000 valid 1 data beef0000",
                                c, arb_req, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!out_valid && waited < 6);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0001) begin
            bad++; $display("[TB] FAIL bp_resume: got valid %b data %h expected valid 1 data beef0001", out_valid, out_data);
        end
    endtask

    task automatic test_lane_full();
        logic [DW-1:0] got [$];
        logic          pending_clear;
        logic [DW-1:0] exp_items [3];
        exp_items[0] = 32'hE000_0000;
        exp_items[1] = 32'hE000_0001;
        exp_items[2] = 32'hE000_0002;
        reset_dut();
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        in_data[1*DW +: DW] = exp_items[0];
        @(negedge clk);
        total++;
        if (in_ready[1] !== 1'b1) begin bad++; $display("[TB] FAIL full_after_one: got %b expected 1", in_ready[1]); end
        in_data[1*DW +: DW] = exp_items[1];
        @(negedge clk);
        total++;
        if (in_ready[1] !== 1'b0) begin bad++; $display("[TB] FAIL full_after_two: got %b expected 0", in_ready[1]); end
        in_data[1*DW +: DW] = exp_items[2];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (in_ready[1] !== 1'b0) begin bad++; $display("[TB] FAIL full_hold_%0d: got %b expected 0", c, in_ready[1]); end
        end
        manual = 1'b0;
        pending_clear = 1'b0;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            @(negedge clk);
            if (pending_clear) begin in_valid = '0; pending_clear = 1'b0; end
            if (out_valid) got.push_back(out_data);
            if (in_valid[1] && in_ready[1]) pending_clear = 1'b1;
        end
        total++;
        if (got.size() != 3) begin
            bad++; $display("[TB] FAIL full_drain_count: got %0d items expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (got[k] !== exp_items[k]) begin
                    bad++; $display("[TB] FAIL full_order_%0d: got %h expected %h", k, got[k], exp_items[k]);
                end
            end
        end
        in_valid = '0;
    endtask

    task automatic test_bad_grant();
        reset_dut();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_data[0 +: DW] = 32'hF00D_0000;
        @(negedge clk);
        in_valid = '0;
        total++;
        if (arb_req !== 4'b0001) begin bad++; $display("[TB] FAIL bad_req: got %b expected 0001", arb_req); end
`ifdef ARB_GRANT_CHECK_EN
        manual_grant = 4'b0000;
`else
        manual_grant = 4'b0011;
`endif
        @(negedge clk);
        manual_grant = '0;
        total++;
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL bad_wait_req: got %b expected 0000", arb_req); end
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bad_no_load: got %b expected 0", out_valid); end
        if (arb_req !== 4'b0001) begin bad++; $display("[TB] FAIL bad_rerequest: got %b expected 0001", arb_req); end
        if (grant_err !== EXP_ERR) begin bad++; $display("[TB] FAIL bad_grant_err: got %b expected %b", grant_err, EXP_ERR); end
        manual_grant = 4'b0001;
        @(negedge clk);
        manual_grant = '0;
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b1 || out_data !== 32'hF00D_0000) begin
            bad++; $display("[TB] FAIL bad_recover: got valid %b data %h expected valid 1 data f00d0000", out_valid, out_data);
        end
        if (grant_err !== EXP_ERR) begin bad++; $display("[TB] FAIL bad_err_sticky: got %b expected %b", grant_err, EXP_ERR); end
    endtask

    task automatic test_reset_mid();
        int waited;
        reset_dut();
        manual    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 4'b1001;
        in_data[0 +: DW]    = 32'h5555_0000;
        in_data[3*DW +: DW] = 32'h5555_0003;
        @(negedge clk);
        in_valid = 4'b0001;
        @(negedge clk);
        in_valid = '0;
        waited = 0;
        while (!out_valid && waited < 10) begin @(negedge clk); waited++; end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_setup_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
        if (arb_req !== '0) begin bad++; $display("[TB] FAIL mid_arb_req: got %b expected 0000", arb_req); end
        if (in_ready !== '1) begin bad++; $display("[TB] FAIL mid_in_ready: got %b expected 1111", in_ready); end
        if (out_data !== '0) begin bad++; $display("[TB] FAIL mid_out_data: got %h expected 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || arb_req !== '0) begin
                bad++; $display("[TB] FAIL mid_stale_%0d: got valid %b req %b expected valid 0 req 0000", c, out_valid, arb_req);
            end
        end
    endtask

    task automatic test_random();
        logic          prev_valid;
        logic          prev_ready;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  model_nonempty;
        reset_dut();
        manual     = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic drain;
            drain = (c >= 480);
            // A freshly loaded item: slot was empty or handed off at the last edge.
            if (out_valid && (!prev_valid || prev_ready)) begin
                total++;
                if (model_q[out_src].size() == 0) begin
                    bad++; $display("[TB] FAIL rnd_src_c%0d: got item from empty lane %0d expected none", c, out_src);
                end else begin
                    logic [DW-1:0] exp_d;
                    exp_d = model_q[out_src].pop_front();
                    if (out_data !== exp_d) begin
                        bad++; $display("[TB] FAIL rnd_data_c%0d: got %h expected %h (lane %0d)", c, out_data, exp_d, out_src);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                exp_ready[i]      = (model_q[i].size() < DEPTH);
                model_nonempty[i] = (model_q[i].size() != 0);
            end
            total += 2;
            if (in_ready !== exp_ready) begin
                bad++; $display("[TB] FAIL rnd_ready_c%0d: got %b expected %b", c, in_ready, exp_ready);
            end
            if ((arb_req & ~model_nonempty) !== '0) begin
                bad++; $display("[TB] FAIL rnd_req_c%0d: got %b expected subset of %b", c, arb_req, model_nonempty);
            end
            out_ready  = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid   = drain ? '0 : N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                in_data[i*DW +: DW] = $urandom();
                if (in_valid[i] && in_ready[i]) model_q[i].push_back(in_data[i*DW +: DW]);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (model_q[i].size() != 0) begin
                bad++; $display("[TB] FAIL rnd_leftover_lane%0d: got %0d undelivered expected 0", i, model_q[i].size());
            end
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rnd_final_valid: got %b expected 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting arb_client_mux bench");
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_lane_full();
        test_bad_grant();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
